// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding, sizes and one-hot helper for the stream demux
package demux_pkg;
    typedef enum logic {IDLE, HOLD} state_t;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] s);
        return {{(N_OUT-1){1'b0}}, 1'b1} << s;
    endfunction
endpackage

// File: rtl/demux_sat_counter.sv
// demux_sat_counter: W-bit up counter that sticks at all-ones, cleared only by rst
module demux_sat_counter
    import demux_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/demux_stream_ctrl.sv
// demux_stream_ctrl: one-beat 1-to-4 stream demux with drop on disabled output; DEMUX_CNT_EN adds xfer_cnt
module demux_stream_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [N_OUT-1:0]  en_mask,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop_pulse,
    output logic              busy
`ifdef DEMUX_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0] xfer_cnt
`endif
);
    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [SEL_W-1:0]   sel_q;
    logic               drop_q;
    logic               accept;
    logic               en_hit;
    logic               done;

    assign done     = (state_q == HOLD) && out_ready[sel_q];
    assign in_ready = (state_q == IDLE) || out_ready[sel_q];
    assign accept   = in_valid && in_ready;
    assign en_hit   = en_mask[in_sel];

    // accepting while holding implies the held beat completes this same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= accept && !en_hit;
            if (accept && en_hit) begin
                state_q <= HOLD;
                data_q  <= in_data;
                sel_q   <= in_sel;
            end else if (accept || done) begin
                state_q <= IDLE;
            end
        end
    end

    assign out_valid  = (state_q == HOLD) ? onehot(sel_q) : '0;
    assign out_data   = data_q;
    assign drop_pulse = drop_q;
    assign busy       = (state_q == HOLD);

`ifdef DEMUX_CNT_EN
    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
        demux_sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (done && (sel_q == SEL_W'(i))),
            .cnt (xfer_cnt[CNT_W*i +: CNT_W])
        );
    end
`endif
endmodule

// File: tb/tb_demux_stream_ctrl.sv
// tb_demux_stream_ctrl: scoreboard bench for demux_stream_ctrl; xfer_cnt checks only under DEMUX_CNT_EN
module tb_demux_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] en_mask;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       drop_pulse;
    logic       busy;
`ifdef DEMUX_CNT_EN
    logic [31:0] xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;
    int drops_seen = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    logic [1:0] mon_sel;

    demux_stream_ctrl #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .en_mask    (en_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .busy       (busy)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    // scoreboard: push accepted beats, pop on completed transfers
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (en_mask[in_sel]) exp_q.push_back({in_sel, in_data});
                else exp_drops++;
            end
            if (drop_pulse) drops_seen++;
            if (|out_valid) begin
                checks++;
                if (!$onehot(out_valid)) begin
                    errors++;
                    $display("FAIL onehot out_valid got %b want one-hot", out_valid);
                end
            end
            if (|(out_valid & out_ready)) begin
                mon_sel = 2'd0;
                for (int k = 0; k < 4; k++) if (out_valid[k]) mon_sel = k[1:0];
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer got sel %0d data %h want none", mon_sel, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({mon_sel, out_data} !== mon_e) begin
                        errors++;
                        $display("FAIL xfer got sel %0d data %h want sel %0d data %h",
                                 mon_sel, out_data, mon_e[9:8], mon_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; en_mask = 4'hF; out_ready = '0;
        tick(); tick();
        checks++;
        if ({out_valid, out_data, drop_pulse, busy, in_ready} !== {4'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h drop=%b busy=%b rdy=%b want 0 00 0 0 1",
                     out_valid, out_data, drop_pulse, busy, in_ready);
        end
`ifdef DEMUX_CNT_EN
        checks++;
        if (xfer_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", xfer_cnt);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; en_mask = 4'hF; out_ready = 4'h4;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, busy} !== {4'b0100, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL basic_hold got v=%b d=%h busy=%b want 0100 a5 1", out_valid, out_data, busy);
        end
        tick();
        checks++;
        if ({out_valid, busy, in_ready, out_data} !== {4'b0, 1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL basic_idle got v=%b busy=%b rdy=%b d=%h want 0 0 1 a5",
                     out_valid, busy, in_ready, out_data);
        end
    endtask

    task automatic test_drop();
`ifdef DEMUX_CNT_EN
        logic [31:0] before = xfer_cnt;
`endif
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11; en_mask = 4'b1101; out_ready = 4'hF;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({drop_pulse, out_valid, busy} !== {1'b1, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL drop_pulse got drop=%b v=%b busy=%b want 1 0 0", drop_pulse, out_valid, busy);
        end
        tick();
        checks++;
        if ({drop_pulse, out_valid} !== {1'b0, 4'b0}) begin
            errors++;
            $display("FAIL drop_once got drop=%b v=%b want 0 0", drop_pulse, out_valid);
        end
`ifdef DEMUX_CNT_EN
        checks++;
        if (xfer_cnt !== before) begin
            errors++;
            $display("FAIL drop_cnt got %h want %h", xfer_cnt, before);
        end
`endif
        en_mask = 4'hF;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h5A; en_mask = 4'hF; out_ready = 4'b0111;
        tick();
        in_valid = 1'b0;
        en_mask = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({out_valid, in_ready, out_data} !== {4'b1000, 1'b0, 8'h5A}) begin
                errors++;
                $display("FAIL stall_%0d got v=%b rdy=%b d=%h want 1000 0 5a", c, out_valid, in_ready, out_data);
            end
            if (c < 4) tick();
        end
        out_ready = 4'b1000;
        tick();
        checks++;
        if ({out_valid, busy} !== {4'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_done got v=%b busy=%b want 0 0", out_valid, busy);
        end
        en_mask = 4'hF;
    endtask

    task automatic test_back_to_back();
        en_mask = 4'hF; out_ready = 4'h1; in_sel = 2'd0; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d got %b want 1", k, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data} !== {4'b0001, 8'(k)}) begin
                errors++;
                $display("FAIL b2b_out_%0d got v=%b d=%h want 0001 %h", k, out_valid, out_data, 8'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b want 0", busy);
        end
`ifdef DEMUX_CNT_EN
        checks++;
        if (xfer_cnt[7:0] !== 8'd4) begin
            errors++;
            $display("FAIL b2b_cnt got %0d want 4", xfer_cnt[7:0]);
        end
`endif
    endtask

    task automatic test_complete_and_drop();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77; en_mask = 4'hF; out_ready = 4'b0010;
        tick();
        in_sel = 2'd2; in_data = 8'h88; en_mask = 4'b1011;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({busy, drop_pulse, out_valid} !== {1'b0, 1'b1, 4'b0}) begin
            errors++;
            $display("FAIL cmp_drop got busy=%b drop=%b v=%b want 0 1 0", busy, drop_pulse, out_valid);
        end
        en_mask = 4'hF;
        tick();
    endtask

    task automatic test_reset_hold();
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h3C; en_mask = 4'hF; out_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({busy, out_valid} !== {1'b1, 4'b1000}) begin
            errors++;
            $display("FAIL rh_held got busy=%b v=%b want 1 1000", busy, out_valid);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({out_valid, busy} !== {4'b0, 1'b0}) begin
            errors++;
            $display("FAIL rh_async got v=%b busy=%b want 0 0", out_valid, busy);
        end
        tick();
        rst = 1'b0;
        out_ready = 4'hF;
        tick(); tick(); tick();
        checks++;
        if ({out_valid, busy, out_data} !== {4'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rh_gone got v=%b busy=%b d=%h want 0 0 00", out_valid, busy, out_data);
        end
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_saturate();
        in_valid = 1'b1; in_sel = 2'd0; en_mask = 4'hF; out_ready = 4'h1;
        for (int k = 0; k < 300; k++) begin
            in_data = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (xfer_cnt !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL sat_cnt got %h want 000000ff", xfer_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_stall();
        test_back_to_back();
        test_complete_and_drop();
        test_reset_hold();
`ifdef DEMUX_CNT_EN
        test_saturate();
`endif
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending got %0d beats want 0", exp_q.size());
        end
        checks++;
        if (drops_seen != exp_drops) begin
            errors++;
            $display("FAIL drops got %0d want %0d", drops_seen, exp_drops);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_stream_ctrl.md
DEMUX_STREAM_CTRL -- requirements
Module: demux_stream_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream beat valid.
REQ-005 Port: in_ready  output  1  controller accepts beat this cycle.
REQ-006 Port: in_data  input  DATA_W  upstream payload.
REQ-007 Port: in_sel  input  2  destination index 0..3, sampled with the beat.
REQ-008 Port: en_mask  input  4  per-output enable; bit i=1 means output i may receive.
REQ-009 Port: out_valid  output  4  one-hot (or zero) valid toward outputs 0..3.
REQ-010 Port: out_ready  input  4  per-output downstream ready.
REQ-011 Port: out_data  output  DATA_W  shared payload bus to all outputs.
REQ-012 Port: drop_pulse  output  1  one-cycle pulse when a beat is discarded.
REQ-013 Port: busy  output  1  high while a beat is held.
REQ-014 Port: xfer_cnt  output  32  four 8-bit counters, output i at bits [8i+7:8i]; present only with DEMUX_CNT_EN.

Function
REQ-015 The block SHALL be a two-state FSM: IDLE (no beat held) and HOLD (one beat held in data_q/sel_q).
REQ-016 in_ready SHALL be 1 in IDLE, and in HOLD equal out_ready[sel_q].
REQ-017 Accept occurs when in_valid and in_ready are both 1.
REQ-018 On accept with en_mask[in_sel]=1: capture in_data->data_q, in_sel->sel_q, next state HOLD.
REQ-019 On accept with en_mask[in_sel]=0: beat discarded, drop_pulse=1 next cycle, next state IDLE unless holding (see REQ-022).
REQ-020 In HOLD: out_valid[sel_q]=1, all other out_valid bits 0, out_data=data_q; in IDLE out_valid=0 and out_data holds last value.
REQ-021 Transfer completes in HOLD when out_ready[sel_q]=1; next state IDLE if no simultaneous accept.
REQ-022 Simultaneous completion and accept of an enabled beat: load new beat, remain HOLD (no bubble; full throughput); of a disabled beat: drop it, go IDLE.
REQ-023 Latency: accepted beat appears on out_valid the cycle after accept.
REQ-024 en_mask SHALL be sampled only at accept; a held beat is delivered even if its mask bit clears later.
REQ-025 out_ready on non-selected outputs SHALL be ignored; held beat waits indefinitely (no timeout).
REQ-026 busy SHALL equal (state==HOLD).

Reset
REQ-027 Asserting rst at any time SHALL immediately force IDLE; held beat is discarded without delivery.
REQ-028 Reset values: out_valid=0, out_data=0, drop_pulse=0, busy=0, in_ready=1 once state is IDLE, xfer_cnt=0.

Configuration
REQ-029 Macro DEMUX_CNT_EN defined: port xfer_cnt and four 8-bit counters exist; counter i increments on each completed transfer to output i, saturates at 255, clears only on rst.
REQ-030 Macro DEMUX_CNT_EN undefined: no counters, no xfer_cnt port; all other behaviour identical.

Structure
REQ-031 Package demux_pkg SHALL hold the state enum (IDLE, HOLD), N_OUT=4, SEL_W=2, CNT_W=8.
REQ-032 One sub-module demux_sat_counter (CNT_W-bit, inc enable, saturating) instantiated four times under DEMUX_CNT_EN.

Verification
REQ-033 Reset, then in_valid=1, in_sel=2, in_data=8'hA5, en_mask=4'hF, out_ready=4'h4 -> next cycle out_valid=4'b0100, out_data=8'hA5; following cycle IDLE.
REQ-034 en_mask=4'b1101, in_sel=1, in_valid=1 -> drop_pulse=1 for exactly one cycle, out_valid stays 0, xfer_cnt unchanged.
REQ-035 Beat to output 3 with out_ready=4'b0111 for 5 cycles -> out_valid=4'b1000 held 5 cycles, in_ready=0; then out_ready[3]=1 -> completes.
REQ-036 Back-to-back beats 8'h01..8'h04 to sel 0, out_ready=4'h1 constant -> one beat per cycle, in_ready stays 1, xfer_cnt[7:0]=4.
REQ-037 rst pulsed while HOLD with beat 8'h3C -> out_valid=0 immediately, beat never delivered, busy=0.
REQ-038 (DEMUX_CNT_EN) 300 transfers to output 0 -> xfer_cnt[7:0]=255, other fields 0.
